// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - default sizing constants and pointer-width helper for the fifo
package fifo_pkg;

    localparam int FIFO_WIDTH = 32;
    localparam int FIFO_DEPTH = 8;

    // One extra MSB beyond the index bits tells full apart from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// rtl/fifo_if.sv - writer/reader signal bundle for the fifo, with dut and tb views
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) ();

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             rd_en;
    logic [WIDTH-1:0] rdata;
    logic             full_flag;
    logic             empty_flag;

    // Flag logic relies on power-of-two depth so the index bits wrap naturally.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "fifo_if: DEPTH must be a power of 2 and at least 2");
    end

    modport dut (
        input  wr_en,
        input  wdata,
        input  rd_en,
        output rdata,
        output full_flag,
        output empty_flag
    );

    modport tb (
        output wr_en,
        output wdata,
        output rd_en,
        input  rdata,
        input  full_flag,
        input  empty_flag
    );

endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock circular FIFO with registered read data
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input logic  clk,
    input logic  rst,
    fifo_if.dut  fifo_intf
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic full, empty;
    logic wr_acc, rd_acc;

    // Both requests are judged against flags from the registered pointers.
    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        wr_acc = fifo_intf.wr_en && !full;
        rd_acc = fifo_intf.rd_en && !empty;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rdata_d = rdata_q;
        if (wr_acc) begin
            wptr_d = wptr_q + {{(PW-1){1'b0}}, 1'b1};
        end
        if (rd_acc) begin
            rptr_d  = rptr_q + {{(PW-1){1'b0}}, 1'b1};
            rdata_d = mem[rptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q[AW-1:0]] <= fifo_intf.wdata;
        end
    end

    assign fifo_intf.rdata      = rdata_q;
    assign fifo_intf.full_flag  = full;
    assign fifo_intf.empty_flag = empty;

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - self-checking bench for fifo against a queue-based reference model
module tb_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) intf ();

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_intf (intf.dut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_rdata;

    // One clock of stimulus; the model accepts requests against occupancy before the edge.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
        bit can_w;
        bit can_r;
        intf.wr_en = w;
        intf.wdata = d;
        intf.rd_en = r;
        can_w = (model_q.size() < DEPTH);
        can_r = (model_q.size() > 0);
        @(posedge clk);
        if (r && can_r) exp_rdata = model_q.pop_front();
        if (w && can_w) model_q.push_back(d);
        #1;
        intf.wr_en = 1'b0;
        intf.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        intf.wr_en = 1'b0;
        intf.rd_en = 1'b0;
        intf.wdata = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        exp_rdata = '0;
        checks++;
        if (intf.rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=%h", intf.rdata, 32'h0);
        end
        checks++;
        if (intf.empty_flag !== 1'b1) begin
            failures++;
            $display("FAIL reset_empty got=%b exp=1", intf.empty_flag);
        end
        checks++;
        if (intf.full_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_full got=%b exp=0", intf.full_flag);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, (i % 2 == 0) ? 32'hD4F40099 : 32'h281B86C4, 1'b0);
            checks++;
            if (intf.empty_flag !== 1'b0) begin
                failures++;
                $display("FAIL fill_empty[%0d] got=%b exp=0", i, intf.empty_flag);
            end
            checks++;
            if (intf.full_flag !== (i == DEPTH - 1)) begin
                failures++;
                $display("FAIL fill_full[%0d] got=%b exp=%b", i, intf.full_flag, (i == DEPTH - 1));
            end
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 32'hBABABABA, 1'b0);
        checks++;
        if (intf.full_flag !== 1'b1) begin
            failures++;
            $display("FAIL overflow_full got=%b exp=1", intf.full_flag);
        end
        checks++;
        if (intf.rdata !== 32'h0) begin
            failures++;
            $display("FAIL overflow_rdata_hold got=%h exp=%h", intf.rdata, 32'h0);
        end
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] want;
        for (int i = 0; i < DEPTH; i++) begin
            want = (i % 2 == 0) ? 32'hD4F40099 : 32'h281B86C4;
            step(1'b0, '0, 1'b1);
            checks++;
            if (intf.rdata !== want || exp_rdata !== want) begin
                failures++;
                $display("FAIL drain_rdata[%0d] got=%h exp=%h", i, intf.rdata, want);
            end
        end
        checks++;
        if (intf.empty_flag !== 1'b1 || intf.full_flag !== 1'b0) begin
            failures++;
            $display("FAIL drain_flags got=e%b/f%b exp=e1/f0", intf.empty_flag, intf.full_flag);
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (intf.rdata !== 32'h281B86C4) begin
                failures++;
                $display("FAIL underflow_rdata[%0d] got=%h exp=%h", i, intf.rdata, 32'h281B86C4);
            end
            checks++;
            if (intf.empty_flag !== 1'b1) begin
                failures++;
                $display("FAIL underflow_empty[%0d] got=%b exp=1", i, intf.empty_flag);
            end
        end
        // A single write must come back out, proving the read pointer did not move.
        step(1'b1, 32'h13579BDF, 1'b0);
        step(1'b0, '0, 1'b1);
        checks++;
        if (intf.rdata !== 32'h13579BDF) begin
            failures++;
            $display("FAIL underflow_ptr got=%h exp=%h", intf.rdata, 32'h13579BDF);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        step(1'b1, 32'h76543210, 1'b0);
        intf.wr_en = 1'b1;
        intf.wdata = 32'hFFFFFFFF;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        exp_rdata = '0;
        checks++;
        if (intf.rdata !== 32'h0 || intf.empty_flag !== 1'b1) begin
            failures++;
            $display("FAIL midreset_async got=%h/e%b exp=%h/e1", intf.rdata, intf.empty_flag, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        intf.wr_en = 1'b0;
        step(1'b1, 32'h89ABCDEF, 1'b0);
        n = 0;
        while (intf.empty_flag === 1'b0 && n < 2 * DEPTH) begin
            step(1'b0, '0, 1'b1);
            n++;
            checks++;
            if (intf.rdata !== 32'h89ABCDEF) begin
                failures++;
                $display("FAIL midreset_read[%0d] got=%h exp=%h", n, intf.rdata, 32'h89ABCDEF);
            end
        end
        checks++;
        if (n !== 1 || intf.empty_flag !== 1'b1) begin
            failures++;
            $display("FAIL midreset_count got=%0d/e%b exp=1/e1", n, intf.empty_flag);
        end
    endtask

    task automatic test_concurrent_wrap();
        logic [WIDTH-1:0] base;
        base = $urandom;
        for (int i = 0; i < 3; i++) step(1'b1, base + WIDTH'(i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, base + WIDTH'(i + 3), 1'b1);
            checks++;
            if (intf.rdata !== base + WIDTH'(i) || intf.rdata !== exp_rdata) begin
                failures++;
                $display("FAIL conc_rdata[%0d] got=%h exp=%h", i, intf.rdata, base + WIDTH'(i));
            end
            checks++;
            if (intf.full_flag !== 1'b0 || intf.empty_flag !== 1'b0 || model_q.size() != 3) begin
                failures++;
                $display("FAIL conc_flags[%0d] got=e%b/f%b exp=e0/f0", i, intf.empty_flag, intf.full_flag);
            end
        end
        while (model_q.size() < DEPTH) step(1'b1, $urandom, 1'b0);
        step(1'b1, 32'hDEADBEEF, 1'b1);
        checks++;
        if (intf.rdata !== base + WIDTH'(12) || intf.full_flag !== 1'b0) begin
            failures++;
            $display("FAIL full_conc got=%h/f%b exp=%h/f0", intf.rdata, intf.full_flag, base + WIDTH'(12));
        end
        while (model_q.size() > 0) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (intf.rdata !== exp_rdata || intf.rdata === 32'hDEADBEEF) begin
                failures++;
                $display("FAIL full_conc_drain got=%h exp=%h", intf.rdata, exp_rdata);
            end
        end
    endtask

    task automatic test_random();
        logic w;
        logic r;
        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            step(w, $urandom, r);
            checks++;
            if (intf.rdata !== exp_rdata
                || intf.empty_flag !== (model_q.size() == 0)
                || intf.full_flag !== (model_q.size() == DEPTH)) begin
                failures++;
                $display("FAIL random[%0d] got=%h/e%b/f%b exp=%h/occ=%0d",
                         i, intf.rdata, intf.empty_flag, intf.full_flag, exp_rdata, model_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_reset_mid_write();
        test_concurrent_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
